muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings and FSM states.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes, sign fix-up at the end.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete immediately with result 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      mag = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      mag = v;
    end
  endfunction

  muldiv_state_t    r_state, w_state_nxt;
  logic [2:0]       r_f3, w_f3_nxt;
  logic [XLEN-1:0]  r_b, w_b_nxt;
  logic [W2-1:0]    r_acc, w_acc_nxt;
  logic             r_neg, w_neg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]  r_result, w_result_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_sa, w_sb, w_neg_start;
  logic             w_bypass;
  logic [XLEN-1:0]  w_bypass_val;
  logic [XLEN:0]    w_sum;
  logic [W2-1:0]    w_mul_step, w_step, w_prod;
  logic [XLEN-1:0]  w_quo, w_rem, w_fix;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Operand sign handling at accept time: which operands are signed and whether the answer is negated
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_sa = rs1[XLEN-1];
        w_sb = rs2[XLEN-1];
      end
      F3_MULHSU: begin
        w_sa = rs1[XLEN-1];
        w_sb = 1'b0;
      end
      default: begin
        w_sa = 1'b0;
        w_sb = 1'b0;
      end
    endcase
    // Remainder follows the dividend sign; everything else follows the product/quotient sign
    if (funct3 == F3_REM) begin
      w_neg_start = w_sa;
    end else begin
      w_neg_start = w_sa ^ w_sb;
    end
  end

`ifdef MULDIV_DIV_EN
  logic          w_div_zero, w_ovf;
  logic [XLEN:0] w_rem_sh, w_diff;
  logic [W2-1:0] w_div_step;

  // Divide-by-zero and INT_MIN/-1 are resolved without iterating
  always_comb begin
    w_div_zero   = funct3[2] && (rs2 == ZERO);
    w_ovf        = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    w_bypass     = w_div_zero || w_ovf;
    w_bypass_val = ZERO;
    if (w_div_zero) begin
      w_bypass_val = funct3[1] ? rs1 : ALL_ONES;
    end else if (w_ovf) begin
      w_bypass_val = funct3[1] ? ZERO : INT_MIN;
    end else begin
      w_bypass_val = ZERO;
    end
  end

  // Restoring divide: acc holds {partial remainder, dividend/quotient bits}
  assign w_rem_sh   = {r_acc[W2-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_step     = r_f3[2] ? w_div_step : w_mul_step;
  assign w_quo      = r_neg ? mag(r_acc[XLEN-1:0], 1'b1) : r_acc[XLEN-1:0];
  assign w_rem      = r_neg ? mag(r_acc[W2-1:XLEN], 1'b1) : r_acc[W2-1:XLEN];
`else
  assign w_bypass     = funct3[2];
  assign w_bypass_val = ZERO;
  assign w_step       = w_mul_step;
  assign w_quo        = ZERO;
  assign w_rem        = ZERO;
`endif

  // Shift-add multiply: acc holds {partial product high, remaining multiplier bits}
  assign w_sum      = {1'b0, r_acc[W2-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_mul_step = {w_sum, r_acc[XLEN-1:1]};
  assign w_prod     = r_neg ? (~r_acc + {{(W2-1){1'b0}}, 1'b1}) : r_acc;

  // Final word selection after sign correction
  always_comb begin
    w_fix = ZERO;
    case (r_f3)
      F3_MUL:                      w_fix = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[W2-1:XLEN];
      F3_DIV, F3_DIVU:             w_fix = w_quo;
      F3_REM, F3_REMU:             w_fix = w_rem;
      default:                     w_fix = ZERO;
    endcase
  end

  // Next-state, datapath and output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_f3_nxt     = r_f3;
    w_b_nxt      = r_b;
    w_acc_nxt    = r_acc;
    w_neg_nxt    = r_neg;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_f3_nxt  = funct3;
            w_b_nxt   = mag(rs2, w_sb);
            w_acc_nxt = {ZERO, mag(rs1, w_sa)};
            w_neg_nxt = w_neg_start;
            w_cnt_nxt = CNT_ZERO;
            if (w_bypass) begin
              w_state_nxt  = DONE;
              w_result_nxt = w_bypass_val;
            end else begin
              w_state_nxt = CALC;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CALC: begin
          w_acc_nxt = w_step;
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = FIX;
          end else begin
            w_state_nxt = CALC;
          end
        end
        FIX: begin
          w_result_nxt = w_fix;
          w_state_nxt  = DONE;
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == CALC) || (w_state_nxt == FIX);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_f3     <= 3'b000;
      r_b      <= ZERO;
      r_acc    <= {W2{1'b0}};
      r_neg    <= 1'b0;
      r_cnt    <= CNT_ZERO;
      r_result <= ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_f3     <= w_f3_nxt;
      r_b      <= w_b_nxt;
      r_acc    <= w_acc_nxt;
      r_neg    <= w_neg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  // Drive one operation from IDLE and measure it; no comparisons here
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int nbusy, output logic dn2);
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
    dn2 = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_table(input string name, input vec_t v[]);
    logic [31:0] r; int lat, nb; logic d2;
    for (int i = 0; i < v.size(); i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, r, lat, nb, d2);
      n_checks++; if (r !== v[i].exp) $display("FAIL %s[%0d] result got %h want %h", name, i, r, v[i].exp); else n_pass++;
      n_checks++; if (lat !== v[i].lat) $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, v[i].lat); else n_pass++;
      n_checks++; if (nb !== v[i].lat - 1) $display("FAIL %s[%0d] busy_cycles got %0d want %0d", name, i, nb, v[i].lat - 1); else n_pass++;
      n_checks++; if (d2 !== 1'b0) $display("FAIL %s[%0d] done_width got %b want 0", name, i, d2); else n_pass++;
    end
  endtask

  task automatic test_mul();
    vec_t v[];
    v = new[9];
    v[0] = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    v[1] = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    v[2] = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    v[3] = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    v[4] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    v[5] = '{F3_MULHU,  32'h80000000, 32'd4,        32'h00000002, 34};
    v[6] = '{F3_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 34};
    v[7] = '{F3_MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34};
    v[8] = '{F3_MULHSU, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 34};
    check_table("mul", v);
  endtask

  task automatic test_div();
    vec_t v[];
    v = new[11];
    v[0]  = '{F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[1]  = '{F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    v[2]  = '{F3_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    v[3]  = '{F3_REMU, 32'd5,        32'd0,        32'h00000005, 1};
    v[4]  = '{F3_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    v[5]  = '{F3_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    v[6]  = '{F3_DIVU, 32'd100,      32'd7,        32'h0000000E, 34};
    v[7]  = '{F3_REMU, 32'd100,      32'd7,        32'h00000002, 34};
    v[8]  = '{F3_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    v[9]  = '{F3_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 34};
    v[10] = '{F3_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
`ifndef MULDIV_DIV_EN
    for (int i = 0; i < v.size(); i++) begin
      v[i].exp = 32'h0;
      v[i].lat = 1;
    end
`endif
    check_table("div", v);
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, nb; logic d2; int seen;
    run_op(F3_MUL, 32'd3, 32'd5, r, lat, nb, d2);
    funct3 = F3_MUL; rs1 = 32'd7; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else n_pass++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else n_pass++;
    seen = (done === 1'b1) ? 1 : 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1; end
    n_checks++; if (seen !== 0) $display("FAIL flush_no_done got %0d want 0", seen); else n_pass++;
    n_checks++; if (result !== 32'd15) $display("FAIL flush_result got %h want %h", result, 32'd15); else n_pass++;
    run_op(F3_MUL, 32'd6, 32'd7, r, lat, nb, d2);
    n_checks++; if (r !== 32'd42) $display("FAIL after_flush_result got %h want %h", r, 32'd42); else n_pass++;
    n_checks++; if (lat !== 34) $display("FAIL after_flush_latency got %0d want 34", lat); else n_pass++;
    // flush together with start in IDLE discards the start
    funct3 = F3_MUL; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_start_busy got %b want 0", busy); else n_pass++;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1; end
    n_checks++; if (seen !== 0) $display("FAIL flush_start_done got %0d want 0", seen); else n_pass++;
    n_checks++; if (result !== 32'd42) $display("FAIL flush_start_result got %h want %h", result, 32'd42); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, nb; logic d2; int seen;
    funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (result !== 32'h0) $display("FAIL rst_mid_result got %h want 0", result); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
    seen = (done === 1'b1) ? 1 : 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1; end
    n_checks++; if (seen !== 0) $display("FAIL rst_mid_no_done got %0d want 0", seen); else n_pass++;
    // reset wins over start and flush
    start = 1'b1; flush = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_prio_busy got %b want 0", busy); else n_pass++;
    run_op(F3_MULHU, 32'h80000000, 32'd4, r, lat, nb, d2);
    n_checks++; if (r !== 32'd2) $display("FAIL rst_recover_result got %h want 2", r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      start = (lat == 3 || lat == 10 || lat == 33) ? 1'b1 : 1'b0;
      funct3 = F3_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    n_checks++; if (lat !== 34) $display("FAIL busy_start_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (result !== 32'd12) $display("FAIL busy_start_result got %h want %h", result, 32'd12); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL done_cycle_busy got %b want 0", busy); else n_pass++;
    // start raised in the done cycle is ignored, then accepted in the following IDLE cycle
    funct3 = F3_MUL; rs1 = 32'd5; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL done_start_ignored got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL idle_start_accepted got %b want 1", busy); else n_pass++;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 34) $display("FAIL b2b_latency got %0d want 34", lat); else n_pass++;
    n_checks++; if (result !== 32'd25) $display("FAIL b2b_result got %h want %h", result, 32'd25); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
